// File: rtl/img_mem_arbiter.sv
// Round-robin arbiter sharing one single-port image memory between the accelerator (m0) and host (m1).
// Define IMG_MEM_ARB_LOCK_EN to add m0_lock/m1_lock burst ownership.
//
// owner state | meaning
// OWN_NONE    | plain round-robin between both masters
// OWN_M0      | m0 holds a locked burst, m1 is blocked
// OWN_M1      | m1 holds a locked burst, m0 is blocked
module img_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              reset,
`ifdef IMG_MEM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic              m0_en,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dataW,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_dataR,
    output logic              m0_rvalid,
    input  logic              m1_en,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dataW,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_dataR,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataR
);

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
        $error("img_mem_arbiter: RD_LAT must be 1 or 2");
    end
    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("img_mem_arbiter: MAX_BURST must be 2..255");
    end

    logic              last_gnt;
    logic              req0, req1;
    logic              gnt0, gnt1;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_i;
    logic              ret_v;
    logic              ret_i;

`ifdef IMG_MEM_ARB_LOCK_EN
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    owner_t     owner, owner_nxt;
    logic [7:0] burst_cnt, burst_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_NONE;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        case (owner)
            OWN_NONE: begin
                if (gnt0 && m0_lock) begin
                    owner_nxt     = OWN_M0;
                    burst_cnt_nxt = '0;
                end else if (gnt1 && m1_lock) begin
                    owner_nxt     = OWN_M1;
                    burst_cnt_nxt = '0;
                end
            end
            OWN_M0: begin
                if (!m0_lock || !m0_en) begin
                    owner_nxt = OWN_NONE;
                end else if (gnt0) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    if (burst_cnt_nxt == BURST_LAST) owner_nxt = OWN_NONE;
                end
            end
            OWN_M1: begin
                if (!m1_lock || !m1_en) begin
                    owner_nxt = OWN_NONE;
                end else if (gnt1) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    if (burst_cnt_nxt == BURST_LAST) owner_nxt = OWN_NONE;
                end
            end
            default: owner_nxt = OWN_NONE;
        endcase
    end

    assign req0 = m0_en && (owner != OWN_M1);
    assign req1 = m1_en && (owner != OWN_M0);
`else
    assign req0 = m0_en;
    assign req1 = m1_en;
`endif

    // On a tie the master that was not granted last wins.
    assign gnt0 = !reset && req0 && (!req1 || last_gnt);
    assign gnt1 = !reset && req1 && (!req0 || !last_gnt);

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;
    assign mem_en = gnt0 || gnt1;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_dataW = '0;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_we    = m0_we;
            mem_dataW = m0_dataW;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_we    = m1_we;
            mem_dataW = m1_dataW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    // Read tags travel alongside the memory pipeline so data returns to its issuer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            tag_i <= '0;
        end else begin
            tag_v[0] <= mem_en && !mem_we;
            tag_i[0] <= gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_i[i] <= tag_i[i-1];
            end
        end
    end

    assign ret_v = !reset && tag_v[RD_LAT-1];
    assign ret_i = tag_i[RD_LAT-1];

    assign m0_rvalid = ret_v && !ret_i;
    assign m1_rvalid = ret_v && ret_i;
    assign m0_dataR  = m0_rvalid ? mem_dataR : '0;
    assign m1_dataR  = m1_rvalid ? mem_dataR : '0;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: one DUT per legal read latency, shared stimulus, queue-based reference model.
// Lock sequences are exercised only when IMG_MEM_ARB_LOCK_EN is defined.
module tb_img_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_en, m0_we, m1_en, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_dataW, m1_dataW;
`ifdef IMG_MEM_ARB_LOCK_EN
    logic        m0_lock = 1'b0;
    logic        m1_lock = 1'b0;
`endif

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_m0_dataR, a_m1_dataR, a_mem_dataW, a_mem_dataR;
    logic [15:0] a_mem_addr;
    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_m0_dataR, b_m1_dataR, b_mem_dataW, b_mem_dataR;
    logic [15:0] b_mem_addr;

    img_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset),
`ifdef IMG_MEM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dataW),
        .m0_gnt(a_m0_gnt), .m0_dataR(a_m0_dataR), .m0_rvalid(a_m0_rvalid),
        .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dataW),
        .m1_gnt(a_m1_gnt), .m1_dataR(a_m1_dataR), .m1_rvalid(a_m1_rvalid),
        .mem_addr(a_mem_addr), .mem_dataW(a_mem_dataW), .mem_en(a_mem_en),
        .mem_we(a_mem_we), .mem_dataR(a_mem_dataR)
    );

    img_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(2), .MAX_BURST(4)) dut_b (
        .clk(clk), .reset(reset),
`ifdef IMG_MEM_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dataW),
        .m0_gnt(b_m0_gnt), .m0_dataR(b_m0_dataR), .m0_rvalid(b_m0_rvalid),
        .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dataW),
        .m1_gnt(b_m1_gnt), .m1_dataR(b_m1_dataR), .m1_rvalid(b_m1_rvalid),
        .mem_addr(b_mem_addr), .mem_dataW(b_mem_dataW), .mem_en(b_mem_en),
        .mem_we(b_mem_we), .mem_dataR(b_mem_dataR)
    );

    function automatic logic [31:0] init_val(int i);
        return (i == 5) ? 32'h11223344 : (32'(i) ^ 32'hA5A50000);
    endfunction

    // Memories: 1-cycle registered read for dut_a, 2-cycle for dut_b.
    logic [31:0] mem_a [0:65535];
    logic [31:0] mem_b [0:65535];
    logic [31:0] rd_b1;
    bit          init_pend = 1'b1;

    always @(posedge clk) begin
        if (init_pend) begin
            for (int i = 0; i < 65536; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
            init_pend <= 1'b0;
        end else begin
            if (a_mem_en) begin
                if (a_mem_we) mem_a[a_mem_addr] <= a_mem_dataW;
                else          a_mem_dataR <= mem_a[a_mem_addr];
            end
            if (b_mem_en) begin
                if (b_mem_we) mem_b[b_mem_addr] <= b_mem_dataW;
                else          rd_b1 <= mem_b[b_mem_addr];
            end
            b_mem_dataR <= rd_b1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who should win, what the memory holds, and what returns when.
    typedef struct {
        int          due;
        logic        idx;
        logic [31:0] data;
    } ret_t;

    logic [31:0] ref_mem [0:65535];
    ret_t        qa[$];
    ret_t        qb[$];
    logic        last_w = 1'b1;
    logic        win_g0, win_g1;
    int          cyc = 0;

    task automatic model_check();
        logic        eg0, eg1, eme, ewe;
        logic [15:0] ea;
        logic [31:0] ed;
        logic        erv0, erv1;
        logic [31:0] ed0, ed1;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!reset) begin
            if (m0_en && m1_en) begin
                if (last_w) eg0 = 1'b1;
                else        eg1 = 1'b1;
            end else begin
                eg0 = m0_en;
                eg1 = m1_en;
            end
        end
        eme = eg0 | eg1;
        ea  = eg0 ? m0_addr  : (eg1 ? m1_addr  : 16'h0);
        ewe = eg0 ? m0_we    : (eg1 ? m1_we    : 1'b0);
        ed  = eg0 ? m0_dataW : (eg1 ? m1_dataW : 32'h0);
        chk("gnt_a", {a_m0_gnt, a_m1_gnt}, {eg0, eg1});
        chk("gnt_b", {b_m0_gnt, b_m1_gnt}, {eg0, eg1});
        chk("mem_a", {a_mem_en, a_mem_we, a_mem_addr, a_mem_dataW}, {eme, ewe, ea, ed});
        chk("mem_b", {b_mem_en, b_mem_we, b_mem_addr, b_mem_dataW}, {eme, ewe, ea, ed});
        win_g0 = eg0;
        win_g1 = eg1;

        erv0 = 1'b0; erv1 = 1'b0; ed0 = '0; ed1 = '0;
        if (!reset && qa.size() > 0 && qa[0].due == cyc) begin
            if (qa[0].idx) begin erv1 = 1'b1; ed1 = qa[0].data; end
            else           begin erv0 = 1'b1; ed0 = qa[0].data; end
            void'(qa.pop_front());
        end
        chk("ret_a", {a_m0_rvalid, a_m1_rvalid, a_m0_dataR, a_m1_dataR}, {erv0, erv1, ed0, ed1});

        erv0 = 1'b0; erv1 = 1'b0; ed0 = '0; ed1 = '0;
        if (!reset && qb.size() > 0 && qb[0].due == cyc) begin
            if (qb[0].idx) begin erv1 = 1'b1; ed1 = qb[0].data; end
            else           begin erv0 = 1'b1; ed0 = qb[0].data; end
            void'(qb.pop_front());
        end
        chk("ret_b", {b_m0_rvalid, b_m1_rvalid, b_m0_dataR, b_m1_dataR}, {erv0, erv1, ed0, ed1});
    endtask

    task automatic model_update();
        ret_t        r;
        logic [15:0] ad;
        if (reset) begin
            last_w = 1'b1;
            qa.delete();
            qb.delete();
        end else if (win_g0 || win_g1) begin
            ad = win_g1 ? m1_addr : m0_addr;
            if (win_g1 ? m1_we : m0_we) begin
                ref_mem[ad] = win_g1 ? m1_dataW : m0_dataW;
            end else begin
                r.idx  = win_g1;
                r.data = ref_mem[ad];
                r.due  = cyc + 1;
                qa.push_back(r);
                r.due  = cyc + 2;
                qb.push_back(r);
            end
            last_w = win_g1;
        end
        cyc++;
    endtask

    // Inputs change just after the rising edge; outputs are sampled after the falling edge.
    task automatic settle();
        @(negedge clk);
        #2;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle_inputs();
        m0_en = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dataW = '0;
        m1_en = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dataW = '0;
    endtask

    typedef struct {
        logic        e0, w0;
        logic [15:0] a0;
        logic [31:0] d0;
        logic        e1, w1;
        logic [15:0] a1;
        logic [31:0] d1;
        logic        g0, g1;
        logic [15:0] ma;
        logic        mw;
        logic [31:0] md;
    } vec_t;

    vec_t vecs[8];

`ifdef IMG_MEM_ARB_LOCK_EN
    task automatic lock_cycle(output logic g0, output logic g1);
        @(negedge clk);
        #2;
        g0 = a_m0_gnt;
        g1 = a_m1_gnt;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k0, k1, ng;
        logic pend0, pend1;
        logic g0, g1;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

        vecs[0] = '{1'b1, 1'b1, 16'h0200, 32'hA0, 1'b0, 1'b0, 16'h0000, 32'h00, 1'b1, 1'b0, 16'h0200, 1'b1, 32'hA0};
        vecs[1] = '{1'b1, 1'b1, 16'h0201, 32'hA1, 1'b1, 1'b1, 16'h0301, 32'hB1, 1'b0, 1'b1, 16'h0301, 1'b1, 32'hB1};
        vecs[2] = '{1'b1, 1'b1, 16'h0201, 32'hA1, 1'b1, 1'b1, 16'h0302, 32'hB2, 1'b1, 1'b0, 16'h0201, 1'b1, 32'hA1};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 32'h00, 1'b0, 1'b0, 16'h0000, 32'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 16'h0203, 32'hA3, 1'b1, 1'b1, 16'h0302, 32'hB2, 1'b0, 1'b1, 16'h0302, 1'b1, 32'hB2};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 32'h00, 1'b1, 1'b1, 16'h0303, 32'hB3, 1'b0, 1'b1, 16'h0303, 1'b1, 32'hB3};
        vecs[6] = '{1'b1, 1'b1, 16'h0203, 32'hA3, 1'b1, 1'b1, 16'h0304, 32'hB4, 1'b1, 1'b0, 16'h0203, 1'b1, 32'hA3};
        vecs[7] = '{1'b1, 1'b0, 16'h0005, 32'h00, 1'b0, 1'b0, 16'h0000, 32'h00, 1'b1, 1'b0, 16'h0005, 1'b0, 32'h00};

        // Reset: every output must be zero, including with a request present.
        idle_inputs();
        reset = 1'b1;
        m0_en = 1'b1;
        settle();
        chk("rst_outputs", {a_m0_gnt, a_m1_gnt, a_mem_en, a_mem_we, a_mem_addr, a_m0_rvalid, a_m1_rvalid}, '0);
        advance();
        idle_inputs();
        settle();
        advance();
        reset = 1'b0;

        foreach (vecs[i]) begin
            m0_en = vecs[i].e0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0; m0_dataW = vecs[i].d0;
            m1_en = vecs[i].e1; m1_we = vecs[i].w1; m1_addr = vecs[i].a1; m1_dataW = vecs[i].d1;
            settle();
            chk("vec", {a_m0_gnt, a_m1_gnt, a_mem_addr, a_mem_we, a_mem_dataW},
                {vecs[i].g0, vecs[i].g1, vecs[i].ma, vecs[i].mw, vecs[i].md});
            advance();
        end
        idle_inputs();
        settle(); advance();
        settle(); advance();

        // m0 reads preloaded word 5.
        m0_en = 1'b1; m0_addr = 16'h0005;
        settle();
        chk("rd5_gnt", a_m0_gnt, 1'b1);
        advance();
        idle_inputs();
        settle();
        chk("rd5_rvalid", {a_m0_rvalid, a_m1_rvalid}, 2'b10);
        chk("rd5_data", a_m0_dataR, 32'h11223344);
        chk("rd5_lat2_early", b_m0_rvalid, 1'b0);
        advance();
        settle();
        chk("rd5_lat2", {b_m0_rvalid, b_m0_dataR}, {1'b1, 32'h11223344});
        advance();

        // m1 writes, m0 reads back.
        m1_en = 1'b1; m1_we = 1'b1; m1_addr = 16'h6300; m1_dataW = 32'hDEADBEEF;
        settle();
        chk("wr_gnt", {a_m0_gnt, a_m1_gnt, a_mem_we}, 3'b011);
        advance();
        idle_inputs();
        m0_en = 1'b1; m0_addr = 16'h6300;
        settle();
        chk("rb_gnt", a_m0_gnt, 1'b1);
        advance();
        idle_inputs();
        settle();
        chk("rb_data", {a_m0_rvalid, a_m0_dataR}, {1'b1, 32'hDEADBEEF});
        advance();
        settle(); advance();

        // Reset lands while a read is in flight.
        m0_en = 1'b1; m0_addr = 16'h0007;
        settle();
        chk("rstmid_gnt", a_m0_gnt, 1'b1);
        advance();
        idle_inputs();
        reset = 1'b1;
        settle();
        chk("rstmid_rv_t1", {a_m0_rvalid, b_m0_rvalid}, 2'b00);
        advance();
        reset = 1'b0;
        settle();
        chk("rstmid_rv_t2", {a_m0_rvalid, b_m0_rvalid}, 2'b00);
        advance();
        m0_en = 1'b1; m0_addr = 16'h0008;
        m1_en = 1'b1; m1_addr = 16'h0009;
        settle();
        chk("rstmid_tie", {a_m0_gnt, a_m1_gnt}, 2'b10);
        advance();
        m0_en = 1'b0;
        settle();
        chk("rstmid_m1", a_m1_gnt, 1'b1);
        advance();
        idle_inputs();
        settle(); advance();
        settle(); advance();

        // Continuous contention from the cycle after reset.
        reset = 1'b1;
        settle(); advance();
        reset = 1'b0;
        k0 = 0; k1 = 0; ng = 0;
        for (int t = 0; t < 20 && (k0 < 4 || k1 < 4); t++) begin
            m0_en = (k0 < 4); m0_we = 1'b0; m0_addr = 16'(k0);
            m1_en = (k1 < 4); m1_we = 1'b0; m1_addr = 16'(100 + k1);
            settle();
            chk("cont_order", {a_m0_gnt, a_m1_gnt}, (ng % 2 == 0) ? 2'b10 : 2'b01);
            if (a_m0_gnt || a_m1_gnt) ng++;
            advance();
            if (win_g0) k0++;
            if (win_g1) k1++;
        end
        chk("cont_done", k0 + k1, 8);
        idle_inputs();
        for (int t = 0; t < 3; t++) begin settle(); advance(); end

        // Randomised traffic with masters holding requests until granted.
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1;
                m0_we = 1'($urandom_range(0, 1));
                m0_addr = 16'($urandom_range(16, 31));
                m0_dataW = $urandom;
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1;
                m1_we = 1'($urandom_range(0, 1));
                m1_addr = 16'($urandom_range(16, 31));
                m1_dataW = $urandom;
            end
            m0_en = pend0;
            m1_en = pend1;
            reset = ($urandom_range(0, 149) == 0);
            settle();
            advance();
            if (win_g0) pend0 = 1'b0;
            if (win_g1) pend1 = 1'b0;
        end
        reset = 1'b0;
        idle_inputs();
        for (int t = 0; t < 3; t++) begin settle(); advance(); end

`ifdef IMG_MEM_ARB_LOCK_EN
        // Locked burst capped at MAX_BURST=4, then m1 gets its turn.
        reset = 1'b1;
        lock_cycle(g0, g1);
        reset = 1'b0;
        m0_lock = 1'b1;
        m0_en = 1'b1; m0_we = 1'b1; m0_addr = 16'h0040;
        m1_en = 1'b1; m1_we = 1'b1; m1_addr = 16'h0041;
        for (int i = 0; i < 5; i++) begin
            lock_cycle(g0, g1);
            chk("lock_burst", {g0, g1}, (i < 4) ? 2'b10 : 2'b01);
        end
        // Lock dropped after two grants: m0 finishes its access, then m1 wins.
        reset = 1'b1;
        lock_cycle(g0, g1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_lock = (i < 2);
            lock_cycle(g0, g1);
            chk("lock_drop", {g0, g1}, (i < 3) ? 2'b10 : 2'b01);
        end
        m0_lock = 1'b0;
        idle_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
